// File: rtl/alu_seq_ctrl_pkg.sv
// Shared encodings for the ALU sequencing front end: operand width, ALU opcodes,
// request opcodes and FSM state encodings.
package alu_seq_ctrl_pkg;

    localparam int DATA_BUS_WIDTH  = 16;
    localparam int ALU_OP_NUM_BITS = 3;
    localparam int REQ_OP_NUM_BITS = 2;

    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_ADD = 3'd0;
    localparam logic [ALU_OP_NUM_BITS-1:0] ALU_OP_SUB = 3'd1;

    typedef enum logic [REQ_OP_NUM_BITS-1:0] {
        REQ_OP_ADD = 2'b00,
        REQ_OP_SUB = 2'b01,
        REQ_OP_CMP = 2'b10,
        REQ_OP_MUL = 2'b11
    } req_op_t;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_MUL_STEP = 2'd2,
        ST_RESP     = 2'd3
    } state_t;

endpackage

// File: rtl/alu_seq_ctrl.sv
// Valid/ready sequencer in front of the combinational alu; optional shift-add
// multiply over the ALU adder when ALU_SEQ_MUL_EN is defined.
module alu_seq_ctrl
    import alu_seq_ctrl_pkg::*;
(
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [REQ_OP_NUM_BITS-1:0]  req_op,
    input  logic [DATA_BUS_WIDTH-1:0]   req_a,
    input  logic [DATA_BUS_WIDTH-1:0]   req_b,
    output logic [DATA_BUS_WIDTH-1:0]   alu_a,
    output logic [DATA_BUS_WIDTH-1:0]   alu_b,
    output logic [ALU_OP_NUM_BITS-1:0]  alu_op,
    input  logic [DATA_BUS_WIDTH-1:0]   alu_result,
    input  logic                        alu_z,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic [DATA_BUS_WIDTH-1:0]   rsp_result,
    output logic                        rsp_z,
    output logic                        rsp_err
);

    localparam int W     = DATA_BUS_WIDTH;
    localparam int CNT_W = $clog2(W);

    state_t             state_reg;
    req_op_t            op_reg;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic               req_ready_reg;
    logic               rsp_valid_reg;
    logic [W-1:0]       rsp_result_reg;
    logic               rsp_z_reg;
    logic               rsp_err_reg;

`ifdef ALU_SEQ_MUL_EN
    logic [W-1:0]       acc_reg;
    logic [W-1:0]       mcand_reg;
    logic [W-1:0]       mplier_reg;
    logic [CNT_W-1:0]   cnt_reg;
    logic [W-1:0]       acc_next;

    assign acc_next = mplier_reg[0] ? alu_result : acc_reg;
`endif

    assign req_ready  = req_ready_reg;
    assign rsp_valid  = rsp_valid_reg;
    assign rsp_result = rsp_result_reg;
    assign rsp_z      = rsp_z_reg;
    assign rsp_err    = rsp_err_reg;

    // ALU inputs are a pure decode of state and operand registers.
    always_comb begin
        alu_a  = '0;
        alu_b  = '0;
        alu_op = ALU_OP_ADD;
        if (state_reg == ST_EXEC) begin
            alu_a  = a_reg;
            alu_b  = b_reg;
            alu_op = (op_reg == REQ_OP_ADD) ? ALU_OP_ADD : ALU_OP_SUB;
        end
`ifdef ALU_SEQ_MUL_EN
        else if (state_reg == ST_MUL_STEP) begin
            alu_a  = acc_reg;
            alu_b  = mcand_reg;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            op_reg         <= REQ_OP_ADD;
            a_reg          <= '0;
            b_reg          <= '0;
            req_ready_reg  <= 1'b1;
            rsp_valid_reg  <= 1'b0;
            rsp_result_reg <= '0;
            rsp_z_reg      <= 1'b0;
            rsp_err_reg    <= 1'b0;
`ifdef ALU_SEQ_MUL_EN
            acc_reg        <= '0;
            mcand_reg      <= '0;
            mplier_reg     <= '0;
            cnt_reg        <= '0;
`endif
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_reg        <= req_op_t'(req_op);
                        a_reg         <= req_a;
                        b_reg         <= req_b;
                        req_ready_reg <= 1'b0;
                        if (req_op_t'(req_op) == REQ_OP_MUL) begin
`ifdef ALU_SEQ_MUL_EN
                            acc_reg    <= '0;
                            mcand_reg  <= req_a;
                            mplier_reg <= req_b;
                            cnt_reg    <= '0;
                            state_reg  <= ST_MUL_STEP;
`else
                            rsp_result_reg <= '0;
                            rsp_z_reg      <= 1'b1;
                            rsp_err_reg    <= 1'b1;
                            state_reg      <= ST_RESP;
`endif
                        end else begin
                            state_reg <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    // Z is taken straight from the ALU, including its carry-aware semantics.
                    rsp_result_reg <= (op_reg == REQ_OP_CMP) ? '0 : alu_result;
                    rsp_z_reg      <= alu_z;
                    rsp_err_reg    <= 1'b0;
                    state_reg      <= ST_RESP;
                end
                ST_MUL_STEP: begin
`ifdef ALU_SEQ_MUL_EN
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_W'(W-1)) begin
                        rsp_result_reg <= acc_next;
                        rsp_z_reg      <= (acc_next == '0);
                        rsp_err_reg    <= 1'b0;
                        state_reg      <= ST_RESP;
                    end
`else
                    state_reg <= ST_IDLE;
`endif
                end
                ST_RESP: begin
                    // First RESP cycle raises valid; later cycles wait for the consumer.
                    if (!rsp_valid_reg) begin
                        rsp_valid_reg <= 1'b1;
                    end else if (rsp_ready) begin
                        rsp_valid_reg <= 1'b0;
                        req_ready_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed, table-driven bench for alu_seq_ctrl with a behavioural alu beside it.
module tb_alu_seq_ctrl;
    import alu_seq_ctrl_pkg::*;

    localparam int W = DATA_BUS_WIDTH;

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        req_valid = 1'b0;
    logic                        req_ready;
    logic [REQ_OP_NUM_BITS-1:0]  req_op = '0;
    logic [W-1:0]                req_a = '0;
    logic [W-1:0]                req_b = '0;
    logic [W-1:0]                alu_a;
    logic [W-1:0]                alu_b;
    logic [ALU_OP_NUM_BITS-1:0]  alu_op;
    logic [W-1:0]                alu_result;
    logic                        alu_z;
    logic                        rsp_valid;
    logic                        rsp_ready = 1'b0;
    logic [W-1:0]                rsp_result;
    logic                        rsp_z;
    logic                        rsp_err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_seq_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_z(alu_z),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_z(rsp_z), .rsp_err(rsp_err)
    );

    // Behavioural alu: W+1-bit sum/difference, Z flags the full W+1-bit value.
    logic [W:0] alu_wide;
    always_comb begin
        alu_wide = '0;
        if (alu_op == ALU_OP_SUB)
            alu_wide = {1'b0, alu_a} - {1'b0, alu_b};
        else
            alu_wide = {1'b0, alu_a} + {1'b0, alu_b};
    end
    assign alu_result = alu_wide[W-1:0];
    assign alu_z      = (alu_wide == '0);

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] res;
        logic        z;
        logic        err;
        int          lat;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_ready_wait"}, {31'd0, req_ready}, 32'd1);
    endtask

    task automatic issue(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!rsp_valid && k < 40) begin
            tick();
            k++;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int k;
        wait_ready(v.name);
        issue(v.op, v.a, v.b);
        chk({v.name, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        wait_valid(k);
        chk({v.name, "_latency"}, k, v.lat);
        chk({v.name, "_result"}, {16'd0, rsp_result}, {16'd0, v.res});
        chk({v.name, "_z"}, {31'd0, rsp_z}, {31'd0, v.z});
        chk({v.name, "_err"}, {31'd0, rsp_err}, {31'd0, v.err});
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({v.name, "_done"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        $display("txn %s op=%0d a=0x%04h b=0x%04h -> result=0x%04h z=%0b err=%0b latency=%0d",
                 v.name, v.op, v.a, v.b, rsp_result, rsp_z, rsp_err, k);
    endtask

    initial begin
        int k;
        int bad;
        vecs.push_back('{"add_basic", 2'b00, 16'h1234, 16'h0001, 16'h1235, 1'b0, 1'b0, 2});
        vecs.push_back('{"sub_equal", 2'b01, 16'h0042, 16'h0042, 16'h0000, 1'b1, 1'b0, 2});
        vecs.push_back('{"cmp_lt",    2'b10, 16'h0005, 16'h0007, 16'h0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"cmp_eq",    2'b10, 16'h0009, 16'h0009, 16'h0000, 1'b1, 1'b0, 2});
        vecs.push_back('{"add_carry", 2'b00, 16'h8000, 16'h8000, 16'h0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"add_wrap",  2'b00, 16'hFFFF, 16'h0001, 16'h0000, 1'b0, 1'b0, 2});
        vecs.push_back('{"add_zero",  2'b00, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b0, 2});
        vecs.push_back('{"sub_borrow",2'b01, 16'h0000, 16'h0001, 16'hFFFF, 1'b0, 1'b0, 2});
`ifdef ALU_SEQ_MUL_EN
        vecs.push_back('{"mul_basic", 2'b11, 16'h0013, 16'h0021, 16'h0273, 1'b0, 1'b0, 17});
        vecs.push_back('{"mul_ovf0",  2'b11, 16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0, 17});
        vecs.push_back('{"mul_max",   2'b11, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 17});
`else
        vecs.push_back('{"mul_unsup", 2'b11, 16'h0013, 16'h0021, 16'h0000, 1'b1, 1'b1, 1});
`endif
        vecs.push_back('{"add_after", 2'b00, 16'h00F0, 16'h000F, 16'h00FF, 1'b0, 1'b0, 2});

        // Reset state
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_fields", {14'd0, rsp_result, rsp_z, rsp_err}, 32'd0);
        chk("rst_alu_drive", {alu_a, alu_b}, 32'd0);
        chk("rst_alu_op", {29'd0, alu_op}, {29'd0, ALU_OP_ADD});

        foreach (vecs[i]) run_vec(vecs[i]);

        // Backpressure: response must hold and new requests be ignored.
        wait_ready("bp");
        issue(2'b00, 16'h0003, 16'h0004);
        wait_valid(k);
        chk("bp_latency", k, 2);
        bad = 0;
        req_valid = 1'b1;
        req_op    = 2'b01;
        req_a     = 16'h5555;
        req_b     = 16'h1111;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!rsp_valid || rsp_result !== 16'h0007 || rsp_z !== 1'b0 ||
                rsp_err !== 1'b0 || req_ready !== 1'b0)
                bad++;
        end
        chk("bp_stable", bad, 0);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk("bp_done", {30'd0, rsp_valid, req_ready}, 32'd1);
        tick();
        chk("bp_no_ghost_req", {30'd0, rsp_valid, req_ready}, 32'd1);
        $display("txn backpressure add 0x0003+0x0004 held 10 cycles result=0x0007");

        // Reset mid-operation aborts without any response.
        wait_ready("abort");
`ifdef ALU_SEQ_MUL_EN
        issue(2'b11, 16'h0013, 16'h0021);
        repeat (7) tick();
`else
        issue(2'b00, 16'h0011, 16'h0022);
        wait_valid(k);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_state", {30'd0, rsp_valid, req_ready}, 32'd1);
        chk("abort_fields", {14'd0, rsp_result, rsp_z, rsp_err}, 32'd0);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (rsp_valid) bad++;
        end
        chk("abort_no_rsp", bad, 0);
        $display("txn reset abort: no response emitted");

        run_vec('{"recover", 2'b01, 16'h1000, 16'h0001, 16'h0FFF, 1'b0, 1'b0, 2});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
